// File: rtl/ddr_burst_writer.sv
// Drains the packer's 96-bit show-ahead frame FIFO into fixed-length Avalon-MM write bursts.
// Optional framing check on the last-beat flag is built when BURST_CHECK_EN is defined.
module ddr_burst_writer #(
  parameter int BURST_LEN = 32,
  parameter int ADDR_W    = 29,
  parameter int DATA_W    = 64,
  parameter int USEDW_W   = 9
) (
  input  logic               clk_100,
  input  logic               reset,
  input  logic [95:0]        fifo_q,
  input  logic               fifo_empty,
  input  logic [USEDW_W-1:0] fifo_usedw,
  output logic               fifo_rdreq,
  output logic [ADDR_W-1:0]  avm_address,
  output logic [5:0]         avm_burstcount,
  output logic               avm_write,
  output logic [DATA_W-1:0]  avm_writedata,
  output logic [7:0]         avm_byteenable,
  input  logic               avm_waitrequest,
  output logic               busy,
  output logic               line_done,
  output logic [15:0]        burst_cnt,
  output logic               burst_err
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [USEDW_W-1:0] THRESH    = USEDW_W'(BURST_LEN);
  localparam logic [BW-1:0]      LAST_BEAT = BW'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t        state_p0;
  state_t        state_nxt;
  logic [BW-1:0] beat_cnt_p0;
  logic          beat_acc;
  logic          last_acc;
  logic          unused_bits;

  assign avm_write      = (state_p0 == BURST);
  assign fifo_rdreq     = avm_write & ~avm_waitrequest;
  assign beat_acc       = fifo_rdreq;
  assign last_acc       = beat_acc && (beat_cnt_p0 == LAST_BEAT);
  assign busy           = (state_p0 != IDLE);
  assign avm_burstcount = avm_write ? 6'(BURST_LEN) : 6'd0;
  assign avm_writedata  = fifo_q[DATA_W-1:0];
  assign avm_byteenable = 8'hFF;

  // Next-state logic; BURST is only entered with a full burst buffered,
  // so the FIFO can never run dry mid-burst.
  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      IDLE:    if (fifo_usedw >= THRESH) state_nxt = LOAD;
      LOAD:    state_nxt = BURST;
      BURST:   if (last_acc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: state, beat counter, burst start address and status
  always_ff @(posedge clk_100) begin
    if (reset) begin
      state_p0    <= IDLE;
      beat_cnt_p0 <= '0;
      avm_address <= '0;
      line_done   <= 1'b0;
      burst_cnt   <= 16'd0;
    end else begin
      state_p0  <= state_nxt;
      line_done <= last_acc & fifo_q[94];
      if (state_p0 == LOAD) begin
        avm_address <= ADDR_W'(fifo_q[92:64]);
        beat_cnt_p0 <= '0;
      end else if (last_acc) begin
        beat_cnt_p0 <= '0;
      end else if (beat_acc) begin
        beat_cnt_p0 <= beat_cnt_p0 + BW'(1);
      end
      if (last_acc) burst_cnt <= burst_cnt + 16'd1;
    end
  end

`ifdef BURST_CHECK_EN
  logic frame_bad;

  // Last-beat flag must appear on the final beat and nowhere else.
  assign frame_bad = beat_acc && ((beat_cnt_p0 == LAST_BEAT) ? ~fifo_q[95] : fifo_q[95]);

  always_ff @(posedge clk_100) begin
    if (reset) begin
      burst_err <= 1'b0;
    end else if (frame_bad) begin
      burst_err <= 1'b1;
    end
  end

  assign unused_bits = ^{fifo_empty, fifo_q[93]};
`else
  assign burst_err   = 1'b0;
  assign unused_bits = ^{fifo_empty, fifo_q[95], fifo_q[93]};
`endif

endmodule

// File: tb/tb_ddr_burst_writer.sv
// Randomised bench for ddr_burst_writer: behavioural FIFO, Avalon sink model and
// burst/line/framing scoreboard.
module tb_ddr_burst_writer;

  localparam int BL = 32;
`ifdef BURST_CHECK_EN
  localparam bit EXP_ERR = 1'b1;
`else
  localparam bit EXP_ERR = 1'b0;
`endif

  logic        clk_100 = 1'b0;
  logic        reset;
  logic [95:0] fifo_q;
  logic        fifo_empty;
  logic [8:0]  fifo_usedw;
  logic        fifo_rdreq;
  logic [28:0] avm_address;
  logic [5:0]  avm_burstcount;
  logic        avm_write;
  logic [63:0] avm_writedata;
  logic [7:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic        busy;
  logic        line_done;
  logic [15:0] burst_cnt;
  logic        burst_err;

  ddr_burst_writer dut (
    .clk_100         (clk_100),
    .reset           (reset),
    .fifo_q          (fifo_q),
    .fifo_empty      (fifo_empty),
    .fifo_usedw      (fifo_usedw),
    .fifo_rdreq      (fifo_rdreq),
    .avm_address     (avm_address),
    .avm_burstcount  (avm_burstcount),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .line_done       (line_done),
    .burst_cnt       (burst_cnt),
    .burst_err       (burst_err)
  );

  always #5 clk_100 = ~clk_100;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Stimulus FIFO contents and the independent expected write stream
  logic [95:0] fq[$];
  logic [95:0] exp_q[$];
  logic [95:0] bw[BL];

  int          m_beat;
  logic [28:0] m_addr;
  logic [15:0] m_bursts;
  logic        m_err;
  logic        m_line_pend;
  bit          stall_prev;
  bit          stall_en;
  logic [28:0] h_addr;
  logic [63:0] h_data;
  int          wr_cnt, ld_cnt, pop_cnt;

  task automatic drive_fifo();
    fifo_q     = (fq.size() > 0) ? fq[0] : 96'd0;
    fifo_empty = (fq.size() == 0);
    fifo_usedw = 9'(fq.size());
  endtask

  task automatic push(input logic [95:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    drive_fifo();
  endtask

  function automatic logic [95:0] mkw(input bit lb, input bit ll, input logic [28:0] a,
                                       input logic [63:0] d);
    return {lb, ll, 1'b1, a, d};
  endfunction

  // eb: beat carrying the last-beat flag; later beats get junk addresses
  task automatic gen_burst(input logic [28:0] a, input bit ll, input int eb, input bit idx_data);
    for (int i = 0; i < BL; i++) begin
      logic [63:0] d;
      logic [28:0] wa;
      d = idx_data ? 64'(i) : {$urandom, $urandom};
      wa = (i == 0) ? a : 29'($urandom);
      bw[i] = mkw(i == eb, ll && (i == BL - 1), wa, d);
    end
  endtask

  task automatic push_burst();
    for (int i = 0; i < BL; i++) push(bw[i]);
  endtask

  // One clock: called just after a falling edge, returns just after the next one.
  task automatic cycle();
    logic [95:0] w;
    bit          do_pop, lnext, bad;
    avm_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    if (stall_prev) begin
      chk("hold_write", 64'(avm_write), 64'(1));
      chk("hold_addr", 64'(avm_address), 64'(h_addr));
      chk("hold_data", avm_writedata, h_data);
    end
    chk("line_done", 64'(line_done), 64'(m_line_pend));
    chk("burst_cnt", 64'(burst_cnt), 64'(m_bursts));
    chk("burst_err", 64'(burst_err), 64'(m_err));
    chk("rdreq", 64'(fifo_rdreq), 64'(avm_write & ~avm_waitrequest));
    if (line_done) ld_cnt++;
    if (avm_write) wr_cnt++;
    do_pop = fifo_rdreq;
    lnext  = 1'b0;
    bad    = 1'b0;
    if (avm_write && !avm_waitrequest) begin
      if (exp_q.size() == 0) begin
        chk("beat_avail", 64'(0), 64'(1));
      end else begin
        w = exp_q.pop_front();
        if (m_beat == 0) m_addr = w[92:64];
        chk("addr", 64'(avm_address), 64'(m_addr));
        chk("burstcount", 64'(avm_burstcount), 64'(BL));
        chk("byteenable", 64'(avm_byteenable), 64'(8'hFF));
        chk("data", avm_writedata, w[63:0]);
        if (m_beat == BL - 1) begin
          m_bursts = m_bursts + 16'd1;
          lnext    = w[94];
          bad      = ~w[95];
          m_beat   = 0;
        end else begin
          bad    = w[95];
          m_beat = m_beat + 1;
        end
      end
    end
    if (EXP_ERR && bad) m_err = 1'b1;
    stall_prev = avm_write && avm_waitrequest;
    h_addr     = avm_address;
    h_data     = avm_writedata;
    @(posedge clk_100);
    if (do_pop) begin
      if (fq.size() == 0) chk("underflow", 64'(0), 64'(1));
      else begin
        w = fq.pop_front();
        pop_cnt++;
      end
    end
    m_line_pend = lnext;
    if (reset) begin
      m_beat      = 0;
      m_bursts    = 16'd0;
      m_err       = 1'b0;
      m_line_pend = 1'b0;
      stall_prev  = 1'b0;
    end
    @(negedge clk_100);
    drive_fifo();
  endtask

  task automatic run_until_idle(input int max_cyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      cycle();
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    chk("drain_timeout", 64'(done), 64'(1));
    cycle();
    cycle();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    stall_en = 1'b0;
    avm_waitrequest = 1'b0;
    m_beat = 0; m_addr = '0; m_bursts = '0; m_err = 1'b0; m_line_pend = 1'b0;
    stall_prev = 1'b0; h_addr = '0; h_data = '0;
    wr_cnt = 0; ld_cnt = 0; pop_cnt = 0;
    drive_fifo();
    @(posedge clk_100);
    @(negedge clk_100);
    cycle();
    chk("rst_write", 64'(avm_write), 64'(0));
    chk("rst_addr", 64'(avm_address), 64'(0));
    chk("rst_rdreq", 64'(fifo_rdreq), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_line_done", 64'(line_done), 64'(0));
    chk("rst_burst_cnt", 64'(burst_cnt), 64'(0));
    chk("rst_burst_err", 64'(burst_err), 64'(0));
    reset = 1'b0;

    // 31 words stay idle; the 32nd starts LOAD on the following cycle
    gen_burst(29'h100, 1'b0, BL - 1, 1'b1);
    for (int i = 0; i < BL - 1; i++) push(bw[i]);
    repeat (4) cycle();
    chk("idle_31_busy", 64'(busy), 64'(0));
    chk("idle_31_write", 64'(avm_write), 64'(0));
    push(bw[BL - 1]);
    chk("pre_load_busy", 64'(busy), 64'(0));
    cycle();
    chk("load_busy", 64'(busy), 64'(1));
    chk("load_write", 64'(avm_write), 64'(0));
    cycle();
    chk("first_write", 64'(avm_write), 64'(1));
    chk("first_addr", 64'(avm_address), 64'(29'h100));
    chk("first_data", avm_writedata, 64'd0);
    run_until_idle(100);
    chk("write_cycles", 64'(wr_cnt), 64'(BL));
    chk("burst_cnt_1", 64'(burst_cnt), 64'(1));
    chk("no_line_done", 64'(ld_cnt), 64'(0));

    // 20 bursts, queued in back-to-back pairs, line end on the last
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    ld_cnt = 0;
    for (int p = 0; p < 10; p++) begin
      gen_burst(29'($urandom), 1'b0, BL - 1, 1'b0);
      push_burst();
      gen_burst(29'($urandom), p == 9, BL - 1, 1'b0);
      push_burst();
      run_until_idle(200);
    end
    chk("line_done_count", 64'(ld_cnt), 64'(1));
    chk("burst_cnt_20", 64'(burst_cnt), 64'(20));

    // Random back-pressure across three buffered bursts
    stall_en = 1'b1;
    pop_cnt = 0;
    for (int b = 0; b < 3; b++) begin
      gen_burst(29'($urandom), 1'b0, BL - 1, 1'b0);
      push_burst();
    end
    run_until_idle(1000);
    stall_en = 1'b0;
    chk("stall_pops", 64'(pop_cnt), 64'(3 * BL));
    chk("stall_fifo_left", 64'(fq.size()), 64'(0));
    chk("burst_cnt_23", 64'(burst_cnt), 64'(23));

    // Misplaced last-beat flag on beat 15; burst still runs full length
    wr_cnt = 0;
    gen_burst(29'($urandom), 1'b0, 15, 1'b0);
    push_burst();
    run_until_idle(200);
    chk("frame_write_cycles", 64'(wr_cnt), 64'(BL));
    chk("frame_err_set", 64'(burst_err), 64'(EXP_ERR));
    gen_burst(29'($urandom), 1'b0, BL - 1, 1'b0);
    push_burst();
    run_until_idle(200);
    chk("frame_err_sticky", 64'(burst_err), 64'(EXP_ERR));
    chk("burst_cnt_25", 64'(burst_cnt), 64'(25));

    // Reset at beat 10 of a burst
    gen_burst(29'($urandom), 1'b0, BL - 1, 1'b0);
    push_burst();
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
        cycle();
        if (m_beat == 10) hit = 1'b1;
      end
      chk("reach_beat10", 64'(hit), 64'(1));
    end
    reset = 1'b1;
    cycle();
    chk("midrst_write", 64'(avm_write), 64'(0));
    chk("midrst_burst_cnt", 64'(burst_cnt), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_err", 64'(burst_err), 64'(0));
    reset = 1'b0;
    fq.delete();
    exp_q.delete();
    drive_fifo();
    repeat (3) cycle();
    chk("post_rst_idle", 64'(busy), 64'(0));
    gen_burst(29'($urandom), 1'b0, BL - 1, 1'b0);
    push_burst();
    run_until_idle(200);
    chk("post_rst_burst", 64'(burst_cnt), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ddr_burst_writer.md
# ddr_burst_writer

Drains the 96-bit frame FIFO filled by the frame-buffer write packer and issues fixed-length Avalon-MM write bursts to the DDR SDRAM controller port. It waits until a complete burst is buffered, streams it under `avm_waitrequest` back-pressure, and reports line completion, burst count and framing errors. It sits between the packer's show-ahead FIFO and the DDR controller in the `clk_100` domain.

## Interface
- `BURST_LEN`, 32: beats per Avalon burst; matches the packer's unit-burst length.
- `ADDR_W`, 29: Avalon word-address width.
- `DATA_W`, 64: Avalon data width.
- `USEDW_W`, 9: FIFO fill-level width.

Ports. One clock; reset is synchronous and active-high.
- `clk_100` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `fifo_q` in 96: show-ahead FIFO word. [95] last beat of burst; [94] last burst of line; [93] valid; [92:64] word address; [63:0] data.
- `fifo_empty` in 1: FIFO empty.
- `fifo_usedw` in USEDW_W: FIFO fill level.
- `fifo_rdreq` out 1: pop request; combinational.
- `avm_address` out ADDR_W: burst start word address; registered.
- `avm_burstcount` out 6: constant BURST_LEN while `avm_write`=1.
- `avm_write` out 1: write request.
- `avm_writedata` out DATA_W: equal to `fifo_q[63:0]`.
- `avm_byteenable` out 8: constant 8'hFF.
- `avm_waitrequest` in 1: slave stall.
- `busy` out 1: high when state is not IDLE.
- `line_done` out 1: one-cycle pulse when a line's final burst completes.
- `burst_cnt` out 16: count of completed bursts; wraps at 16'hFFFF→0.
- `burst_err` out 1: sticky framing error.

## Operation
- States: IDLE, LOAD, BURST.
- IDLE → LOAD when `fifo_usedw >= BURST_LEN`; otherwise stays in IDLE.
- LOAD, 1 cycle: latch `avm_address <= fifo_q[92:64]` (first word of the burst); clear the beat counter; → BURST.
- BURST:
  - `avm_write`=1.
  - `fifo_rdreq = avm_write & ~avm_waitrequest`; a beat is accepted on the same cycle.
  - The beat counter (0..BURST_LEN-1) increments per accepted beat.
  - On acceptance of beat BURST_LEN-1 → IDLE.
  - `burst_cnt` increments.
  - If `fifo_q[94]`=1 on that beat, `line_done` pulses on the next cycle.
- Only address bits of the first word are used. Address fields in later words are ignored, including the pre-incremented address the packer places on beats 30–31.
- `fifo_q[93]` is not used for flow control. The packer writes only valid words.
- FIFO never underflows: BURST is entered only with ≥BURST_LEN words buffered, and this block is the sole reader.
- Bursts are never aborted or shortened by this block.

## Timing
- Reset values: `avm_write`=0, `avm_address`=0, `fifo_rdreq`=0, `busy`=0, `line_done`=0, `burst_cnt`=0, `burst_err`=0; state IDLE.
- Threshold met in IDLE at cycle N → LOAD at N+1 → first beat presented at N+2.
- With `avm_waitrequest`=0 throughout, a burst occupies BURST_LEN cycles. The minimum burst-to-burst period is BURST_LEN+2 cycles (IDLE and LOAD gaps).
- The IDLE gap also covers the one-cycle `fifo_usedw` update lag after the last pop.
- `avm_address`, `avm_burstcount`, `avm_writedata` and `avm_write` hold stable while `avm_waitrequest`=1.
- `reset` asserted mid-burst: all outputs take reset values at the next edge. The DDR controller is reset by the same source.

## Configuration
- `BURST_CHECK_EN` defined:
  - `burst_err` sets when beat BURST_LEN-1 is accepted with `fifo_q[95]`=0.
  - `burst_err` also sets when any earlier beat is accepted with `fifo_q[95]`=1.
  - Once set, it stays set until reset.
  - The burst still completes all BURST_LEN beats.
- `BURST_CHECK_EN` undefined: no check logic is built and `burst_err` is tied to 0.

## Test plan
- Reset, 32 words at address 0x100, data = beat index, bit95 on word 31, `avm_waitrequest`=0:
  - `avm_write` high 32 cycles from the cycle after LOAD, with `avm_address`=0x100 and `avm_burstcount`=32.
  - Data 0..31, then `burst_cnt`=1, `line_done` stays 0.
- 20 bursts with bit94 set on the last word of burst 20 → exactly one `line_done` pulse, one cycle after that burst's final beat; `burst_cnt`=20.
- Random `avm_waitrequest` (~50%) during a burst:
  - Exactly 32 pops; no data lost or duplicated.
  - Outputs held stable while stalled.
- Load 31 words → stays IDLE and `busy`=0. Add the 32nd word → LOAD on the following cycle.
- With `BURST_CHECK_EN`, bit95 on word 15 instead of 31 → `burst_err`=1 after beat 15; burst still completes 32 beats; error persists until `reset`.
- Assert `reset` at beat 10 → `avm_write`=0, `burst_cnt`=0 and state IDLE at the next edge.
